// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale terminal: product barcode table,
// entry FSM states and a nibble-insert helper used by the keypad entry logic.
package sale_terminal_pkg;

  localparam int PRODUCT_COUNT = 12;
  localparam int BARCODE_W     = 16;
  localparam int DIGIT_W       = 4;
  localparam int MAX_DIGITS    = BARCODE_W / DIGIT_W;

  // Entry 0 sits in the lowest slice, so PRODUCT_TABLE[i] is product index i.
  localparam logic [PRODUCT_COUNT-1:0][BARCODE_W-1:0] PRODUCT_TABLE = {
    16'h1213, 16'h1342, 16'h4321, 16'h3112,
    16'h2144, 16'h2134, 16'h3214, 16'h3133,
    16'h3121, 16'h4133, 16'h4132, 16'h3124
  };

  typedef enum logic {
    ST_ENTRY,
    ST_LOOKUP
  } state_t;

  // Digit position 0 is the leftmost nibble [15:12].
  function automatic logic [BARCODE_W-1:0] set_nibble(
    input logic [BARCODE_W-1:0] code,
    input logic [2:0]           pos,
    input logic [DIGIT_W-1:0]   val
  );
    logic [BARCODE_W-1:0] result;
    result = code;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (pos == 3'(i)) result[BARCODE_W-1-DIGIT_W*i -: DIGIT_W] = val;
    end
    return result;
  endfunction

endpackage

// File: rtl/barcode_entry_controller_lookup.sv
// Combinational product-table search: 16-bit code -> {hit, index}.
// Lowest matching index wins should the table ever hold duplicates.
module barcode_lookup
  import sale_terminal_pkg::*;
(
  input  logic [BARCODE_W-1:0] code,
  output logic                 hit,
  output logic [3:0]           index
);

  always_comb begin
    hit   = 1'b0;
    index = 4'd0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = PRODUCT_COUNT - 1; i >= 0; i--) begin
      if (code == PRODUCT_TABLE[i]) begin
        hit   = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/barcode_entry_controller.sv
// Keypad barcode entry: collects digits 1..4, handles edits and looks up the code on Enter.
// Define BARCODE_ENTRY_TIMEOUT_EN to discard partial entries after TIMEOUT_CYCLES idle cycles.
module barcode_entry_controller
  import sale_terminal_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DigitValid,
  input  logic [2:0]           Digit_in,
  input  logic                 Backspace,
  input  logic                 Clear,
  input  logic                 Enter,
  output logic [BARCODE_W-1:0] Barcode_out,
  output logic [2:0]           NumOfBarcodeDigitsEntered,
  output logic                 Busy,
  output logic                 ProductValid,
  output logic [3:0]           ProductIndex,
  output logic                 InvalidBarcode
);

  state_t     state;
  logic       lookup_hit;
  logic [3:0] lookup_index;
  logic       digit_legal;

`ifdef BARCODE_ENTRY_TIMEOUT_EN
  logic [31:0] idle_count;
`endif

  barcode_lookup u_lookup (
    .code  (Barcode_out),
    .hit   (lookup_hit),
    .index (lookup_index)
  );

  assign digit_legal = (Digit_in != 3'd0) && (Digit_in <= 3'd4);

  // Strobes are mutually exclusive by priority: the highest one present is the
  // only one acted on, even when its action turns out to be a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= ST_ENTRY;
      Barcode_out               <= '0;
      NumOfBarcodeDigitsEntered <= 3'd0;
      Busy                      <= 1'b0;
      ProductValid              <= 1'b0;
      ProductIndex              <= 4'd0;
      InvalidBarcode            <= 1'b0;
`ifdef BARCODE_ENTRY_TIMEOUT_EN
      idle_count                <= '0;
`endif
    end else begin
      ProductValid   <= 1'b0;
      InvalidBarcode <= 1'b0;
`ifdef BARCODE_ENTRY_TIMEOUT_EN
      idle_count     <= '0;
`endif
      case (state)
        ST_ENTRY: begin
          if (Clear) begin
            Barcode_out               <= '0;
            NumOfBarcodeDigitsEntered <= 3'd0;
          end else if (Backspace) begin
            if (NumOfBarcodeDigitsEntered != 3'd0) begin
              Barcode_out <= set_nibble(Barcode_out, NumOfBarcodeDigitsEntered - 3'd1, 4'd0);
              NumOfBarcodeDigitsEntered <= NumOfBarcodeDigitsEntered - 3'd1;
            end
          end else if (DigitValid) begin
            if (digit_legal && NumOfBarcodeDigitsEntered < 3'(MAX_DIGITS)) begin
              Barcode_out <= set_nibble(Barcode_out, NumOfBarcodeDigitsEntered, {1'b0, Digit_in});
              NumOfBarcodeDigitsEntered <= NumOfBarcodeDigitsEntered + 3'd1;
            end
          end else if (Enter) begin
            if (NumOfBarcodeDigitsEntered == 3'(MAX_DIGITS)) begin
              state <= ST_LOOKUP;
              Busy  <= 1'b1;
            end else begin
              InvalidBarcode <= 1'b1;
            end
          end else begin
`ifdef BARCODE_ENTRY_TIMEOUT_EN
            if (NumOfBarcodeDigitsEntered != 3'd0) begin
              if (idle_count == TIMEOUT_CYCLES - 1) begin
                Barcode_out               <= '0;
                NumOfBarcodeDigitsEntered <= 3'd0;
              end else begin
                idle_count <= idle_count + 32'd1;
              end
            end
`else
            // Without the timeout a partial entry is held until edited.
`endif
          end
        end
        ST_LOOKUP: begin
          ProductValid   <= lookup_hit;
          InvalidBarcode <= ~lookup_hit;
          if (lookup_hit) ProductIndex <= lookup_index;
          Barcode_out               <= '0;
          NumOfBarcodeDigitsEntered <= 3'd0;
          Busy                      <= 1'b0;
          state                     <= ST_ENTRY;
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_entry_controller.sv
// Self-checking bench for barcode_entry_controller: directed vector table,
// reset/timeout sequences and randomized strobes against a queue-based model.
module tb_barcode_entry_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        DigitValid;
  logic [2:0]  Digit_in;
  logic        Backspace;
  logic        Clear;
  logic        Enter;
  logic [15:0] Barcode_out;
  logic [2:0]  NumOfBarcodeDigitsEntered;
  logic        Busy;
  logic        ProductValid;
  logic [3:0]  ProductIndex;
  logic        InvalidBarcode;

  int checks = 0;
  int errors = 0;

  barcode_entry_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .DigitValid                (DigitValid),
    .Digit_in                  (Digit_in),
    .Backspace                 (Backspace),
    .Clear                     (Clear),
    .Enter                     (Enter),
    .Barcode_out               (Barcode_out),
    .NumOfBarcodeDigitsEntered (NumOfBarcodeDigitsEntered),
    .Busy                      (Busy),
    .ProductValid              (ProductValid),
    .ProductIndex              (ProductIndex),
    .InvalidBarcode            (InvalidBarcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [2:0]  d;
    logic        bs;
    logic        clr;
    logic        ent;
    logic [15:0] bc;
    logic [2:0]  cnt;
    logic        busy;
    logic        pv;
    logic        inv;
    logic [3:0]  idx;
  } vec_t;

  vec_t vecs[$];

  int tbl[12] = '{'h3124, 'h4132, 'h4133, 'h3121, 'h3133, 'h3214,
                  'h2134, 'h2144, 'h3112, 'h4321, 'h1342, 'h1213};

  // Reference model state: digits held, pending lookup, last matched index.
  int   m_digits[$];
  bit   m_pending;
  int   m_index;
  logic m_pv;
  logic m_inv;

  task automatic add(input logic dv, input logic [2:0] d, input logic bs, input logic clr,
                     input logic ent, input logic [15:0] bc, input logic [2:0] cnt,
                     input logic busy, input logic pv, input logic inv, input logic [3:0] idx);
    vec_t v;
    v.dv = dv; v.d = d; v.bs = bs; v.clr = clr; v.ent = ent;
    v.bc = bc; v.cnt = cnt; v.busy = busy; v.pv = pv; v.inv = inv; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic dv, input logic [2:0] d, input logic bs,
                                input logic clr, input logic ent);
    DigitValid = dv; Digit_in = d; Backspace = bs; Clear = clr; Enter = ent;
    @(posedge clk);
    #1;
    DigitValid = 1'b0; Digit_in = 3'd0; Backspace = 1'b0; Clear = 1'b0; Enter = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [15:0] bc, input logic [2:0] cnt,
                              input logic busy, input logic pv, input logic inv,
                              input logic [3:0] idx);
    check({tag, ".barcode"}, Barcode_out, bc);
    check({tag, ".count"}, 16'(NumOfBarcodeDigitsEntered), 16'(cnt));
    check({tag, ".busy"}, 16'(Busy), 16'(busy));
    check({tag, ".valid"}, 16'(ProductValid), 16'(pv));
    check({tag, ".invalid"}, 16'(InvalidBarcode), 16'(inv));
    check({tag, ".index"}, 16'(ProductIndex), 16'(idx));
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] code;
    code = 16'h0;
    for (int i = 0; i < m_digits.size(); i++) code[15 - 4*i -: 4] = 4'(m_digits[i]);
    return code;
  endfunction

  // One clock of the intended behaviour, expressed in terms of a digit queue.
  task automatic model_step(input logic dv, input logic [2:0] d, input logic bs,
                            input logic clr, input logic ent);
    int found;
    m_pv = 1'b0;
    m_inv = 1'b0;
    if (m_pending) begin
      found = -1;
      for (int i = 0; i < 12; i++) if (found < 0 && tbl[i] == int'(model_code())) found = i;
      if (found >= 0) begin
        m_pv = 1'b1;
        m_index = found;
      end else begin
        m_inv = 1'b1;
      end
      m_digits.delete();
      m_pending = 1'b0;
    end else if (clr) begin
      m_digits.delete();
    end else if (bs) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (dv) begin
      if (d >= 1 && d <= 4 && m_digits.size() < 4) m_digits.push_back(int'(d));
    end else if (ent) begin
      if (m_digits.size() == 4) m_pending = 1'b1;
      else m_inv = 1'b1;
    end
  endtask

  initial begin
    logic       r_dv, r_bs, r_clr, r_ent;
    logic [2:0] r_d;
    int         sel;

    rst = 1'b1;
    DigitValid = 1'b0; Digit_in = 3'd0; Backspace = 1'b0; Clear = 1'b0; Enter = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    //  dv  d     bs clr ent  barcode   cnt  busy pv inv idx
    add(1, 3'd3, 0, 0, 0, 16'h3000, 3'd1, 0, 0, 0, 4'd0);
    add(1, 3'd1, 0, 0, 0, 16'h3100, 3'd2, 0, 0, 0, 4'd0);
    add(1, 3'd2, 0, 0, 0, 16'h3120, 3'd3, 0, 0, 0, 4'd0);
    add(0, 3'd0, 1, 0, 0, 16'h3100, 3'd2, 0, 0, 0, 4'd0);
    add(0, 3'd0, 0, 1, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd0);
    add(1, 3'd2, 0, 0, 0, 16'h2000, 3'd1, 0, 0, 0, 4'd0);
    add(1, 3'd1, 0, 0, 0, 16'h2100, 3'd2, 0, 0, 0, 4'd0);
    add(0, 3'd0, 0, 0, 1, 16'h2100, 3'd2, 0, 0, 1, 4'd0);
    add(0, 3'd0, 0, 0, 0, 16'h2100, 3'd2, 0, 0, 0, 4'd0);
    add(1, 3'd5, 0, 0, 0, 16'h2100, 3'd2, 0, 0, 0, 4'd0);
    add(1, 3'd0, 0, 0, 0, 16'h2100, 3'd2, 0, 0, 0, 4'd0);
    add(1, 3'd1, 0, 0, 0, 16'h2110, 3'd3, 0, 0, 0, 4'd0);
    add(1, 3'd3, 0, 1, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd0);
    add(0, 3'd0, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd0);
    add(1, 3'd1, 0, 0, 0, 16'h1000, 3'd1, 0, 0, 0, 4'd0);
    add(1, 3'd2, 0, 0, 0, 16'h1200, 3'd2, 0, 0, 0, 4'd0);
    add(1, 3'd1, 0, 0, 0, 16'h1210, 3'd3, 0, 0, 0, 4'd0);
    add(1, 3'd3, 0, 0, 0, 16'h1213, 3'd4, 0, 0, 0, 4'd0);
    add(1, 3'd3, 0, 0, 0, 16'h1213, 3'd4, 0, 0, 0, 4'd0);
    add(0, 3'd0, 0, 0, 1, 16'h1213, 3'd4, 1, 0, 0, 4'd0);
    add(0, 3'd0, 0, 0, 0, 16'h0000, 3'd0, 0, 1, 0, 4'd11);
    add(0, 3'd0, 0, 0, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd11);
    add(1, 3'd4, 0, 0, 0, 16'h4000, 3'd1, 0, 0, 0, 4'd11);
    add(1, 3'd4, 0, 0, 0, 16'h4400, 3'd2, 0, 0, 0, 4'd11);
    add(1, 3'd4, 0, 0, 0, 16'h4440, 3'd3, 0, 0, 0, 4'd11);
    add(1, 3'd4, 0, 0, 0, 16'h4444, 3'd4, 0, 0, 0, 4'd11);
    add(0, 3'd0, 0, 0, 1, 16'h4444, 3'd4, 1, 0, 0, 4'd11);
    add(1, 3'd2, 1, 1, 1, 16'h0000, 3'd0, 0, 0, 1, 4'd11);
    add(0, 3'd0, 0, 0, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd11);
    add(1, 3'd2, 0, 0, 0, 16'h2000, 3'd1, 0, 0, 0, 4'd11);
    add(1, 3'd3, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0, 4'd11);
    add(1, 3'd1, 0, 0, 1, 16'h1000, 3'd1, 0, 0, 0, 4'd11);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].dv, vecs[i].d, vecs[i].bs, vecs[i].clr, vecs[i].ent);
      check_output($sformatf("vec%0d", i), vecs[i].bc, vecs[i].cnt, vecs[i].busy,
                   vecs[i].pv, vecs[i].inv, vecs[i].idx);
    end

    // Idle behaviour with a single held digit.
    apply_stimulus(0, 3'd0, 0, 1, 0);
    apply_stimulus(1, 3'd1, 0, 0, 0);
`ifdef BARCODE_ENTRY_TIMEOUT_EN
    repeat (7) apply_stimulus(0, 3'd0, 0, 0, 0);
    check_output("timeout_pre", 16'h1000, 3'd1, 0, 0, 0, 4'd11);
    apply_stimulus(0, 3'd0, 0, 0, 0);
    check_output("timeout", 16'h0000, 3'd0, 0, 0, 0, 4'd11);
`else
    repeat (20) apply_stimulus(0, 3'd0, 0, 0, 0);
    check_output("no_timeout", 16'h1000, 3'd1, 0, 0, 0, 4'd11);
`endif
    apply_stimulus(0, 3'd0, 0, 1, 0);

    // Reset while a lookup is in flight must suppress the result pulse.
    apply_stimulus(1, 3'd4, 0, 0, 0);
    apply_stimulus(1, 3'd3, 0, 0, 0);
    apply_stimulus(1, 3'd2, 0, 0, 0);
    apply_stimulus(1, 3'd1, 0, 0, 0);
    apply_stimulus(0, 3'd0, 0, 0, 1);
    check_output("lookup_busy", 16'h4321, 3'd4, 1, 0, 0, 4'd11);
    rst = 1'b1;
    apply_stimulus(0, 3'd0, 0, 0, 0);
    rst = 1'b0;
    check_output("rst_lookup", 16'h0000, 3'd0, 0, 0, 0, 4'd0);
    apply_stimulus(0, 3'd0, 0, 0, 0);
    check_output("rst_after", 16'h0000, 3'd0, 0, 0, 0, 4'd0);

    // Randomized strobes; at least one strobe per cycle keeps any idle timer quiet.
    m_digits.delete();
    m_pending = 1'b0;
    m_index = 0;
    for (int n = 0; n < 600; n++) begin
      sel   = int'($urandom_range(0, 19));
      r_d   = 3'($urandom_range(0, 7));
      r_dv  = (sel < 12) || ($urandom_range(0, 9) == 0);
      r_bs  = (sel == 12 || sel == 13) || ($urandom_range(0, 15) == 0);
      r_clr = (sel == 14) || ($urandom_range(0, 31) == 0);
      r_ent = (sel >= 15) || ($urandom_range(0, 15) == 0);
      if (sel < 12 && r_d == 3'd0) r_d = 3'($urandom_range(1, 4));
      model_step(r_dv, r_d, r_bs, r_clr, r_ent);
      apply_stimulus(r_dv, r_d, r_bs, r_clr, r_ent);
      check_output($sformatf("rand%0d", n), model_code(), 3'(m_digits.size()), m_pending,
                   m_pv, m_inv, 4'(m_index));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
